hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline control unit for the four-stage core (fetch/decode → register access → execute → write-back). It detects register hazards and selects operand forwarding. It also turns execute-stage mispredictions into flushes and freezes the pipeline while a data-memory access is outstanding. It drives the stall/flush enables of the fetch_decode and register_access stage registers and the bypass selects of the register_access operand muxes.

## Interface
Parameters:
- `REG_ADDR_W`, 5, register-number width
- `PERF_W`, 32, perf-counter width (used only with `HAZARD_PERF_CNT_EN`)

Ports:
- `clk` in 1: core clock
- `reset` in 1: asynchronous, active-high reset
- `rs_a`, `rs_b` in 5: source registers of the instruction in register_access
- `use_a`, `use_b` in 1: that source is actually read (not pc/immediate)
- `ex_rd` in 5, `ex_wen` in 1, `ex_is_load` in 1: destination of the execute-stage instruction
- `wb_rd` in 5, `wb_wen` in 1: destination of the write-back instruction
- `mispredict` in 1: execute-stage branch/jalr redirect this cycle
- `dmem_req` in 1, `dmem_ack` in 1: data-memory request/completion
- `stall_fd`, `stall_ra` out 1: hold the fetch_decode / register_access registers
- `flush_fd`, `flush_ra` out 1: load a bubble into the stage register
- `bubble_ex` out 1: insert a NOP into execute
- `fwd_a`, `fwd_b` out 2: 0 = register file, 1 = execute result, 2 = write-back value
- `stall_cycles`, `flush_count` out `PERF_W`: perf counters (only with `HAZARD_PERF_CNT_EN`)

## Operation
- States: `INIT`, `RUN`, `MEM_WAIT`, `REDIRECT`.
- Register x0 never matches a hazard or a forward.
- **INIT**
  - Entered on reset.
  - flush_fd = flush_ra = 1.
  - Moves to RUN on the first clock edge after reset is released.
- **RUN, forwarding**
  - fwd_a = 1 if use_a && ex_wen && !ex_is_load && ex_rd == rs_a.
  - Otherwise fwd_a = 2 if use_a && wb_wen && wb_rd == rs_a.
  - Otherwise fwd_a = 0.
  - Execute takes priority over write-back. fwd_b is the same using rs_b/use_b.
- **RUN, load-use**
  - Condition: ex_is_load && ex_wen && ex_rd matches a used nonzero source.
  - Response: stall_fd = stall_ra = 1 and bubble_ex = 1 for one cycle.
  - The load then reaches write-back, and the next cycle forwards from write-back (fwd = 2).
- **RUN, mispredict**
  - flush_fd = flush_ra = 1 and bubble_ex = 0, same cycle.
  - Overrides load-use stall and forwarding; fwd outputs are forced to 0.
  - Next state is REDIRECT.
- **REDIRECT**
  - One cycle with no outputs asserted (refetch from the corrected pc).
  - Returns to RUN. Hazard checks resume in that cycle.
- **MEM_WAIT**
  - Entered when dmem_req && !dmem_ack in RUN.
  - stall_fd = stall_ra = 1 and bubble_ex = 0 (execute holds).
  - Leaves on dmem_ack.
  - A mispredict seen during MEM_WAIT is latched in `pending_flush`. On ack it produces the RUN-mispredict response, then REDIRECT.
- **Simultaneous events in RUN**
  - Mispredict together with dmem_req && !dmem_ack: MEM_WAIT wins and the mispredict is latched.
- **Reset mid-operation**
  - Asynchronous return to INIT. pending_flush is cleared.

## Timing
- Forwarding, stall, flush and bubble outputs are combinational from the inputs and the current state. No extra pipeline latency is added.
- State and pending_flush are registered on the rising edge of `clk`.
- Reset values:
  - state = INIT, pending_flush = 0.
  - flush_fd = flush_ra = 1.
  - stall_fd = stall_ra = bubble_ex = 0, fwd_a = fwd_b = 0.
  - Counters = 0.
- Load-use penalty: exactly 1 cycle.
- Mispredict penalty: flush cycle + REDIRECT cycle.
- dmem_ack in the same cycle as dmem_req: no MEM_WAIT entry and no stall.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - stall_cycles counts each cycle with stall_ra = 1.
  - flush_count counts each cycle with flush_ra = 1 outside INIT.
  - Both counters saturate at all-ones.
- Undefined: the counter ports are tied to 0 and no counter registers are built.

## Structure
- Shared package `pipeline_ctrl_pkg`:
  - state enum (`INIT`/`RUN`/`MEM_WAIT`/`REDIRECT`)
  - fwd select constants `FWD_REG`/`FWD_EX`/`FWD_WB`
  - `REG_ZERO`
- One sub-module, `forward_select`: combinational, one instance per operand; takes rs/use/ex/wb fields and returns the 2-bit select.

## Test plan
- After reset, release: flush_fd = flush_ra = 1 for one cycle, then all outputs 0 in RUN.
- ex_rd = 5 (ALU, ex_wen) with rs_a = 5 → fwd_a = 1. With wb_rd = 5 as well → still 1. Set rs_a = 0 with ex_rd = 0 → fwd_a = 0.
- Load ex_rd = 7, rs_b = 7 → one cycle of stall_fd = stall_ra = bubble_ex = 1. Next cycle, with wb_rd = 7 → fwd_b = 2 and no stall.
- mispredict together with a load-use hazard → flush_fd = flush_ra = 1, stall = 0, fwd = 0. Next cycle REDIRECT with all outputs 0.
- dmem_req held 3 cycles before ack, with mispredict in wait cycle 2 → stall for 3 cycles, then a flush cycle, then REDIRECT. With `HAZARD_PERF_CNT_EN`: stall_cycles = 3, flush_count = 1.
- Assert reset during MEM_WAIT with pending_flush set → immediate INIT outputs; after release no stale flush beyond the INIT cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: controller states,
// operand bypass select encodings and the hard-wired zero register number.
package pipeline_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } ctrl_state_e;

  // Operand bypass selects for the register_access operand muxes
  localparam logic [1:0] FWD_REG = 2'd0;  // register file
  localparam logic [1:0] FWD_EX  = 2'd1;  // execute-stage result
  localparam logic [1:0] FWD_WB  = 2'd2;  // write-back value

  // x0 is hard-wired to zero and never takes part in hazards or bypassing
  localparam int unsigned REG_ZERO = 0;

  // True when a register number names x0
  function automatic logic is_reg_zero(input logic [31:0] reg_num);
    return reg_num == REG_ZERO;
  endfunction

endpackage

// File: rtl/forward_select.sv
// Bypass select for one register_access operand. Execute-stage results win
// over write-back values; loads in execute cannot forward (their data is not
// ready yet) and are handled by the load-use stall instead.
module forward_select
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs,
  input  logic                  i_use,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_wen,
  input  logic                  i_ex_is_load,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_wen,
  output logic [1:0]            o_fwd
);

  logic w_src_live;

  assign w_src_live = i_use && !is_reg_zero(32'(i_rs));

  // Priority select: execute, then write-back, else register file
  always_comb begin
    o_fwd = FWD_REG;
    if (w_src_live && i_ex_wen && !i_ex_is_load && (i_ex_rd == i_rs)) begin
      o_fwd = FWD_EX;
    end else if (w_src_live && i_wb_wen && (i_wb_rd == i_rs)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline control for the four-stage core: operand bypass selection,
// load-use stalls, mispredict flushes and data-memory wait freezes.
// Optional feature macro: HAZARD_PERF_CNT_EN builds saturating stall/flush
// perf counters; without it the counter ports are tied to zero.
module hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PERF_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rs_a,
  input  logic [REG_ADDR_W-1:0] rs_b,
  input  logic                  use_a,
  input  logic                  use_b,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_wen,
  input  logic                  mispredict,
  input  logic                  dmem_req,
  input  logic                  dmem_ack,
  output logic                  stall_fd,
  output logic                  stall_ra,
  output logic                  flush_fd,
  output logic                  flush_ra,
  output logic                  bubble_ex,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic [PERF_W-1:0]     stall_cycles,
  output logic [PERF_W-1:0]     flush_count
);

  ctrl_state_e r_state;
  ctrl_state_e w_state_next;
  logic        r_pending_flush;
  logic        w_pending_next;

  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic        w_hit_a;
  logic        w_hit_b;
  logic        w_load_use;
  logic        w_mem_block;

  forward_select #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_a (
    .i_rs         (rs_a),
    .i_use        (use_a),
    .i_ex_rd      (ex_rd),
    .i_ex_wen     (ex_wen),
    .i_ex_is_load (ex_is_load),
    .i_wb_rd      (wb_rd),
    .i_wb_wen     (wb_wen),
    .o_fwd        (w_fwd_a)
  );

  forward_select #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_b (
    .i_rs         (rs_b),
    .i_use        (use_b),
    .i_ex_rd      (ex_rd),
    .i_ex_wen     (ex_wen),
    .i_ex_is_load (ex_is_load),
    .i_wb_rd      (wb_rd),
    .i_wb_wen     (wb_wen),
    .o_fwd        (w_fwd_b)
  );

  // Load in execute whose destination feeds a live source in register_access
  always_comb begin
    w_hit_a    = use_a && (rs_a == ex_rd);
    w_hit_b    = use_b && (rs_b == ex_rd);
    w_load_use = ex_is_load && ex_wen && !is_reg_zero(32'(ex_rd)) && (w_hit_a || w_hit_b);
    w_mem_block = dmem_req && !dmem_ack;
  end

  // State and latched-mispredict registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= INIT;
      r_pending_flush <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_pending_flush <= w_pending_next;
    end
  end

  // Next state and stage-register controls
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending_flush;
    stall_fd       = 1'b0;
    stall_ra       = 1'b0;
    flush_fd       = 1'b0;
    flush_ra       = 1'b0;
    bubble_ex      = 1'b0;
    fwd_a          = FWD_REG;
    fwd_b          = FWD_REG;

    unique case (r_state)
      INIT: begin
        flush_fd     = 1'b1;
        flush_ra     = 1'b1;
        w_state_next = RUN;
      end

      // Refetch cycle after a flush: nothing asserted
      REDIRECT: begin
        w_state_next = RUN;
      end

      // The ack cycle of MEM_WAIT is evaluated like RUN, with a latched
      // mispredict standing in for a live one.
      RUN, MEM_WAIT: begin
        if ((r_state == MEM_WAIT) && !dmem_ack) begin
          stall_fd       = 1'b1;
          stall_ra       = 1'b1;
          fwd_a          = w_fwd_a;
          fwd_b          = w_fwd_b;
          w_pending_next = r_pending_flush | mispredict;
        end else if ((r_state == RUN) && w_mem_block) begin
          // Memory wait beats a same-cycle mispredict, which is kept for later
          stall_fd       = 1'b1;
          stall_ra       = 1'b1;
          fwd_a          = w_fwd_a;
          fwd_b          = w_fwd_b;
          w_state_next   = MEM_WAIT;
          w_pending_next = mispredict;
        end else if (mispredict || r_pending_flush) begin
          flush_fd       = 1'b1;
          flush_ra       = 1'b1;
          w_state_next   = REDIRECT;
          w_pending_next = 1'b0;
        end else begin
          fwd_a          = w_fwd_a;
          fwd_b          = w_fwd_b;
          stall_fd       = w_load_use;
          stall_ra       = w_load_use;
          bubble_ex      = w_load_use;
          w_state_next   = RUN;
          w_pending_next = 1'b0;
        end
      end

      default: begin
        w_state_next   = INIT;
        w_pending_next = 1'b0;
      end
    endcase
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cycles;
  logic [PERF_W-1:0] r_flush_count;

  // Saturating perf counters; the reset-time INIT flush is not a real flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (stall_ra && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + PERF_W'(1);
      end
      if (flush_ra && (r_state != INIT) && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + PERF_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: directed scenarios followed by
// randomized traffic, all compared against a behavioural reference model.
module tb_hazard_controller;

  localparam int unsigned RW = 5;
  localparam int unsigned PW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] rs_a, rs_b, ex_rd, wb_rd;
  logic          use_a, use_b, ex_wen, ex_is_load, wb_wen;
  logic          mispredict, dmem_req, dmem_ack;
  logic          stall_fd, stall_ra, flush_fd, flush_ra, bubble_ex;
  logic [1:0]    fwd_a, fwd_b;
  logic [PW-1:0] stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  // Reference model: controller phase plus a "flush owed" flag
  typedef enum int {PhInit, PhRun, PhMemWait, PhRedirect} phase_e;
  phase_e      m_phase;
  bit          m_owed;
  int unsigned m_stalls;
  int unsigned m_flushes;

  hazard_controller #(
    .REG_ADDR_W (RW),
    .PERF_W     (PW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rs_a         (rs_a),
    .rs_b         (rs_b),
    .use_a        (use_a),
    .use_b        (use_b),
    .ex_rd        (ex_rd),
    .ex_wen       (ex_wen),
    .ex_is_load   (ex_is_load),
    .wb_rd        (wb_rd),
    .wb_wen       (wb_wen),
    .mispredict   (mispredict),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .stall_fd     (stall_fd),
    .stall_ra     (stall_ra),
    .flush_fd     (flush_fd),
    .flush_ra     (flush_ra),
    .bubble_ex    (bubble_ex),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs, input logic u);
    if (!u || rs == 0) return 2'd0;
    if (ex_wen && !ex_is_load && ex_rd == rs) return 2'd1;
    if (wb_wen && wb_rd == rs) return 2'd2;
    return 2'd0;
  endfunction

  task automatic clear_inputs();
    rs_a = '0; rs_b = '0; ex_rd = '0; wb_rd = '0;
    use_a = 0; use_b = 0; ex_wen = 0; ex_is_load = 0; wb_wen = 0;
    mispredict = 0; dmem_req = 0; dmem_ack = 0;
  endtask

  // Called just after a negedge with inputs settled: compare every output
  // against the model, then advance the model to what the next edge does.
  task automatic step();
    logic [1:0] efa, efb;
    logic       es, eb, ef, lu, waiting, newwait, redirect_now;
    #1;
    efa = 0; efb = 0; es = 0; eb = 0; ef = 0;
    lu = ex_is_load && ex_wen && ex_rd != 0 &&
         ((use_a && rs_a == ex_rd) || (use_b && rs_b == ex_rd));
    waiting      = (m_phase == PhMemWait) && !dmem_ack;
    newwait      = (m_phase == PhRun) && dmem_req && !dmem_ack;
    redirect_now = 0;
    if (reset) begin
      m_phase = PhInit; m_owed = 0; m_stalls = 0; m_flushes = 0;
    end
    if (reset || m_phase == PhInit) begin
      ef = 1;
    end else if (m_phase == PhRedirect) begin
      // nothing asserted
    end else if (waiting || newwait) begin
      es = 1; efa = ref_fwd(rs_a, use_a); efb = ref_fwd(rs_b, use_b);
    end else if (mispredict || m_owed) begin
      ef = 1; redirect_now = 1;
    end else begin
      es = lu; eb = lu; efa = ref_fwd(rs_a, use_a); efb = ref_fwd(rs_b, use_b);
    end

    check_eq("stall_fd", stall_fd, es);
    check_eq("stall_ra", stall_ra, es);
    check_eq("flush_fd", flush_fd, ef);
    check_eq("flush_ra", flush_ra, ef);
    check_eq("bubble_ex", bubble_ex, eb);
    check_eq("fwd_a", fwd_a, efa);
    check_eq("fwd_b", fwd_b, efb);
`ifdef HAZARD_PERF_CNT_EN
    check_eq("stall_cycles", stall_cycles, m_stalls);
    check_eq("flush_count", flush_count, m_flushes);
`else
    check_eq("stall_cycles", stall_cycles, 0);
    check_eq("flush_count", flush_count, 0);
`endif

    if (!reset) begin
      if (es && m_stalls != 32'hFFFF_FFFF) m_stalls++;
      if (ef && m_phase != PhInit && m_flushes != 32'hFFFF_FFFF) m_flushes++;
      if (m_phase == PhInit || m_phase == PhRedirect) begin
        m_phase = PhRun;
      end else if (waiting) begin
        m_owed = m_owed || mispredict;
      end else if (newwait) begin
        m_phase = PhMemWait; m_owed = mispredict;
      end else if (redirect_now) begin
        m_phase = PhRedirect; m_owed = 0;
      end else begin
        m_phase = PhRun; m_owed = 0;
      end
    end
  endtask

  task automatic tick();
    step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; clear_inputs();
    tick();
    reset = 0;
  endtask

  initial begin
    m_phase = PhInit; m_owed = 0; m_stalls = 0; m_flushes = 0;
    reset = 1; clear_inputs();
    @(negedge clk);
    tick();
    reset = 0;

    // Reset release: one INIT flush cycle, then quiet RUN
    step(); check_eq("plan_init_flush", flush_ra, 1); @(negedge clk);
    step(); check_eq("plan_run_quiet", {stall_ra, flush_ra, bubble_ex, fwd_a, fwd_b}, 0);
    @(negedge clk);

    // Execute bypass, execute-over-writeback priority, x0 exclusion
    ex_rd = 5; ex_wen = 1; rs_a = 5; use_a = 1;
    step(); check_eq("plan_fwd_ex", fwd_a, 1); @(negedge clk);
    wb_rd = 5; wb_wen = 1;
    step(); check_eq("plan_fwd_ex_prio", fwd_a, 1); @(negedge clk);
    rs_a = 0; ex_rd = 0; wb_rd = 0;
    step(); check_eq("plan_fwd_x0", fwd_a, 0); @(negedge clk);

    // Load-use: one stall cycle, then write-back bypass
    clear_inputs(); ex_rd = 7; ex_wen = 1; ex_is_load = 1; rs_b = 7; use_b = 1;
    step(); check_eq("plan_loaduse", {stall_fd, stall_ra, bubble_ex}, 3'b111); @(negedge clk);
    ex_rd = 0; ex_wen = 0; ex_is_load = 0; wb_rd = 7; wb_wen = 1;
    step(); check_eq("plan_after_load", {stall_ra, fwd_b}, 3'b010); @(negedge clk);

    // Mispredict overrides a load-use hazard, then one quiet REDIRECT cycle
    clear_inputs(); ex_rd = 3; ex_wen = 1; ex_is_load = 1; rs_a = 3; use_a = 1;
    mispredict = 1;
    step(); check_eq("plan_mp_flush", {flush_fd, flush_ra, stall_ra, fwd_a}, 5'b11000);
    @(negedge clk);
    clear_inputs(); rs_a = 4; use_a = 1; ex_rd = 4; ex_wen = 1;
    step(); check_eq("plan_redirect", {flush_ra, stall_ra, fwd_a}, 0); @(negedge clk);

    // Memory wait with a mispredict inside: 3 stalls, flush, redirect
    clear_inputs(); do_reset(); tick();
    dmem_req = 1; tick();
    mispredict = 1; tick();
    mispredict = 0; tick();
    dmem_ack = 1;
    step(); check_eq("plan_mem_flush", flush_ra, 1); @(negedge clk);
    clear_inputs();
    step(); check_eq("plan_mem_redirect", flush_ra, 0); @(negedge clk);
`ifdef HAZARD_PERF_CNT_EN
    step(); check_eq("plan_cnt_stall", stall_cycles, 3);
    check_eq("plan_cnt_flush", flush_count, 1); @(negedge clk);
`else
    tick();
`endif

    // Reset during MEM_WAIT with a pending flush: no stale flush afterwards
    dmem_req = 1; tick();
    mispredict = 1; tick();
    reset = 1;
    step(); check_eq("plan_rst_init", {flush_ra, stall_ra}, 2'b10); @(negedge clk);
    reset = 0; clear_inputs();
    tick();
    step(); check_eq("plan_rst_no_stale", flush_ra, 0); @(negedge clk);

    // Randomized traffic with occasional mid-run resets
    for (int i = 0; i < 3000; i++) begin
      rs_a       = RW'($urandom_range(0, 3));
      rs_b       = RW'($urandom_range(0, 3));
      ex_rd      = RW'($urandom_range(0, 3));
      wb_rd      = RW'($urandom_range(0, 3));
      use_a      = 1'($urandom);
      use_b      = 1'($urandom);
      ex_wen     = 1'($urandom);
      ex_is_load = ($urandom_range(0, 2) == 0);
      wb_wen     = 1'($urandom);
      mispredict = ($urandom_range(0, 7) == 0);
      dmem_req   = ($urandom_range(0, 3) == 0);
      dmem_ack   = 1'($urandom);
      reset      = ($urandom_range(0, 96) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
